// File: rtl/fpm_pkg.sv
// fpm_pkg: shared types and constants for the multiplier operand sequencer.
package fpm_pkg;
   typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_RES, HOLD_RES} state_t;
   localparam logic [31:0] QNAN = 32'h7FC00000;
   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
   } pair_t;
endpackage

// File: rtl/fpm_pair_fifo.sv
// fpm_pair_fifo: synchronous FIFO of operand pairs with occupancy output.
module fpm_pair_fifo
   import fpm_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_push,
   input  logic                   i_pop,
   input  pair_t                  i_data,
   output pair_t                  o_data,
   output logic [$clog2(DEPTH):0] o_level
);
   localparam int AW = $clog2(DEPTH);
   pair_t         r_mem [DEPTH];
   logic [AW-1:0] r_wr, r_rd;
   logic [AW:0]   r_level;
   logic          w_push, w_pop;
   assign w_push  = i_push && (r_level != (AW+1)'(DEPTH));
   assign w_pop   = i_pop && (r_level != '0);
   assign o_data  = r_mem[r_rd];
   assign o_level = r_level;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_level <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= i_data;
            r_wr        <= r_wr + AW'(1);
         end
         if (w_pop) r_rd <= r_rd + AW'(1);
         r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end
endmodule

// File: rtl/fpm_operand_seq.sv
// fpm_operand_seq: queues operand pairs, feeds them A-then-B to the multiplier, holds the product.
// Optional watchdog enabled by defining FPM_SEQ_TIMEOUT_EN.
module fpm_operand_seq
   import fpm_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [31:0]                 pair_a,
   input  logic [31:0]                 pair_b,
   input  logic                        pair_valid,
   output logic                        pair_ready,
   output logic [31:0]                 number_in,
   output logic                        number_a_valid,
   input  logic                        number_a_ready,
   output logic                        number_b_valid,
   input  logic                        number_b_ready,
   input  logic [31:0]                 number_out,
   input  logic                        result_valid,
   output logic [31:0]                 res_data,
   output logic                        res_valid,
   input  logic                        res_ready,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        timeout_err
);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("fpm_operand_seq: FIFO_DEPTH must be a power of two >= 2, TIMEOUT_CYCLES >= 1");
   end
   state_t      r_state, w_state_nxt;
   pair_t       w_head;
   logic [31:0] r_a_hold, r_b_hold, r_res_data, w_res_data_nxt;
   logic        r_a_valid, r_b_valid, r_res_valid;
   logic        w_a_valid_nxt, w_b_valid_nxt, w_res_valid_nxt, w_push, w_pop;
`ifdef FPM_SEQ_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] r_cnt;
   logic          r_tmo_err, w_run, w_tmo;
   assign w_run       = r_state inside {SEND_A, SEND_B, WAIT_RES};
   assign w_tmo       = w_run && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
   assign timeout_err = r_tmo_err;
`else
   assign timeout_err = 1'b0;
`endif
   assign pair_ready     = fifo_level != LW'(FIFO_DEPTH);
   assign w_push         = pair_valid && pair_ready;
   assign w_pop          = (r_state == IDLE) && (fifo_level != '0);
   assign busy           = r_state != IDLE;
   assign number_a_valid = r_a_valid;
   assign number_b_valid = r_b_valid;
   assign res_data       = r_res_data;
   assign res_valid      = r_res_valid;
   assign number_in      = (r_state == SEND_A) ? r_a_hold : (r_state == SEND_B) ? r_b_hold : '0;
   fpm_pair_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  ({pair_a, pair_b}),
      .o_data  (w_head),
      .o_level (fifo_level)
   );
   // valid ^ ready: raise after ready is seen, drop on transfer, hold if ready falls meanwhile
   always_comb begin
      w_state_nxt     = r_state;
      w_a_valid_nxt   = r_a_valid;
      w_b_valid_nxt   = r_b_valid;
      w_res_valid_nxt = r_res_valid;
      w_res_data_nxt  = r_res_data;
      case (r_state)
         IDLE:     w_state_nxt = (fifo_level != '0) ? SEND_A : IDLE;
         SEND_A: begin
            w_a_valid_nxt = r_a_valid ^ number_a_ready;
            w_state_nxt   = (r_a_valid && number_a_ready) ? SEND_B : SEND_A;
         end
         SEND_B: begin
            w_b_valid_nxt = r_b_valid ^ number_b_ready;
            w_state_nxt   = (r_b_valid && number_b_ready) ? WAIT_RES : SEND_B;
         end
         WAIT_RES: begin
            w_state_nxt     = result_valid ? HOLD_RES : WAIT_RES;
            w_res_valid_nxt = result_valid;
            w_res_data_nxt  = result_valid ? number_out : r_res_data;
         end
         HOLD_RES: begin
            w_state_nxt     = res_ready ? IDLE : HOLD_RES;
            w_res_valid_nxt = !res_ready;
         end
         default:  w_state_nxt = IDLE;
      endcase
`ifdef FPM_SEQ_TIMEOUT_EN
      if (w_tmo) begin
         w_state_nxt     = HOLD_RES;
         w_res_data_nxt  = QNAN;
         w_res_valid_nxt = 1'b1;
         w_a_valid_nxt   = 1'b0;
         w_b_valid_nxt   = 1'b0;
      end
`endif
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_a_hold    <= '0;
         r_b_hold    <= '0;
         r_a_valid   <= 1'b0;
         r_b_valid   <= 1'b0;
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_a_valid   <= w_a_valid_nxt;
         r_b_valid   <= w_b_valid_nxt;
         r_res_valid <= w_res_valid_nxt;
         r_res_data  <= w_res_data_nxt;
         if (w_pop) begin
            r_a_hold <= w_head.a;
            r_b_hold <= w_head.b;
         end
      end
   end
`ifdef FPM_SEQ_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt     <= '0;
         r_tmo_err <= 1'b0;
      end else begin
         r_cnt     <= (!w_run || w_state_nxt != r_state) ? '0 : r_cnt + CW'(1);
         r_tmo_err <= r_tmo_err | w_tmo;
      end
   end
`endif
endmodule
